// File: rtl/wb_burst_ram_slave.sv
// Wishbone B3 RAM responder with CTI/BTE incremental bursts; classic ack one cycle after request.
// Bursts ack every cycle once started; stb low or cyc low ends the access, errors give one err cycle.
module wb_burst_ram_slave #(
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter int              DEPTH     = 16,
  parameter logic [AW-1:0]   BASE_ADDR = 32'h9000_0000
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  output logic [DW-1:0]     wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE, CLASSIC, BURST, ERR} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;

  logic [DW-1:0]   mem [DEPTH];

  logic            req;
  logic            req_err;
  logic            mem_we;
  logic [IW-1:0]   req_idx;
  logic [IW-1:0]   wrap_mask;
  logic [IW-1:0]   idx_nxt;

  assign req     = wb_cyc_i & wb_stb_i;
  assign req_idx = wb_adr_i[IW+1:2];
  assign req_err = (wb_adr_i[AW-1:IW+2] != BASE_ADDR[AW-1:IW+2]) || (wb_adr_i[1:0] != 2'b00);

  // Wrapping bursts only advance the low index bits; linear advances all of them.
  always_comb begin
    wrap_mask = '1;
    case (wb_bte_i)
      2'b01:   wrap_mask = IW'(3);
      2'b10:   wrap_mask = IW'(7);
      2'b11:   wrap_mask = IW'(15);
      default: wrap_mask = '1;
    endcase
  end

  assign idx_nxt = (idx_q & ~wrap_mask) | ((idx_q + IW'(1)) & wrap_mask);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d = req_idx;
          dat_d = mem[req_idx];
          if (req_err) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (wb_cti_i == 3'b010) begin
            state_d = BURST;
            ack_d   = 1'b1;
          end else begin
            state_d = CLASSIC;
            ack_d   = 1'b1;
          end
        end
      end
      CLASSIC: begin
        mem_we  = req & wb_we_i;
        state_d = IDLE;
      end
      BURST: begin
        // ack is always high here, so any cycle with cyc&stb completes a beat.
        if (req) begin
          mem_we = wb_we_i;
          idx_d  = idx_nxt;
          dat_d  = mem[idx_nxt];
          if (wb_cti_i == 3'b111) begin
            state_d = IDLE;
          end else begin
            ack_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset; a beat in flight while reset is low is dropped.
  always_ff @(posedge wb_clk) begin
    if (mem_we && wb_rst) begin
      for (int b = 0; b < SW; b++) begin
        if (wb_sel_i[b]) begin
          mem[idx_q][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
        end
      end
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// Directed plus randomized bench for wb_burst_ram_slave against an array-based memory model.
module tb_wb_burst_ram_slave;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h9000_0000;

  logic          wb_clk;
  logic          wb_rst;
  logic [31:0]   wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    wb_bte_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_rty_o;

  int            errors = 0;
  int            checks = 0;
  logic [31:0]   ref_mem [DEPTH];
  logic [31:0]   bdat [16];

  wb_burst_ram_slave #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_cti_i (wb_cti_i),
    .wb_bte_i (wb_bte_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .wb_rty_o (wb_rty_o)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic idle_bus();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_cti_i = 3'b000; wb_bte_i = 2'b00; wb_sel_i = 4'h0;
    wb_adr_i = '0; wb_dat_i = '0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    return (a < BASE) || (a >= BASE + 32'(DEPTH * 4)) || (a % 4 != 0);
  endfunction

  // Word visited on beat k of a burst starting at word s.
  function automatic int burst_idx(input int s, input int bte, input int k);
    int n;
    if (bte == 0) return (s + k) % DEPTH;
    n = 2 << bte;
    return (s / n) * n + (s + k) % n;
  endfunction

  task automatic classic(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input string tag);
    int idx;
    idx = int'((a - BASE) / 4) % DEPTH;
    wb_adr_i = a; wb_we_i = w; wb_dat_i = d; wb_sel_i = s; wb_cti_i = 3'b000;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    check({tag, "_ack_pre"}, {31'b0, wb_ack_o}, 32'd0);
    step();
    if (addr_bad(a)) begin
      check({tag, "_err"}, {31'b0, wb_err_o}, 32'd1);
      check({tag, "_noack"}, {31'b0, wb_ack_o}, 32'd0);
      idle_bus();
      step();
      check({tag, "_err_end"}, {31'b0, wb_err_o}, 32'd0);
    end else begin
      check({tag, "_ack"}, {31'b0, wb_ack_o}, 32'd1);
      check({tag, "_noerr"}, {31'b0, wb_err_o}, 32'd0);
      if (!w) check({tag, "_rdata"}, wb_dat_o, ref_mem[idx]);
      step();
      if (w) ref_mem[idx] = merge(ref_mem[idx], d, s);
      idle_bus();
      check({tag, "_ack_end"}, {31'b0, wb_ack_o}, 32'd0);
    end
  endtask

  task automatic burst(input logic [31:0] a, input logic [1:0] bte, input logic w,
                       input int n, input string tag);
    int s;
    int idx;
    s = int'((a - BASE) / 4) % DEPTH;
    wb_adr_i = a; wb_we_i = w; wb_dat_i = bdat[0]; wb_sel_i = 4'hF;
    wb_bte_i = bte; wb_cti_i = 3'b010; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    step();
    for (int k = 0; k < n; k++) begin
      idx = burst_idx(s, int'(bte), k);
      wb_adr_i = BASE + 32'(idx * 4);
      wb_dat_i = bdat[k];
      wb_cti_i = (k == n - 1) ? 3'b111 : 3'b010;
      check($sformatf("%s_ack%0d", tag, k), {31'b0, wb_ack_o}, 32'd1);
      check($sformatf("%s_err%0d", tag, k), {31'b0, wb_err_o}, 32'd0);
      if (!w) check($sformatf("%s_rdata%0d", tag, k), wb_dat_o, ref_mem[idx]);
      step();
      if (w) ref_mem[idx] = bdat[k];
    end
    idle_bus();
    check({tag, "_ack_end"}, {31'b0, wb_ack_o}, 32'd0);
  endtask

  initial begin
    int          kind;
    int          len;
    logic [31:0] a;

    wb_rst = 1'b0;
    idle_bus();
    #1;
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    check("rst_err", {31'b0, wb_err_o}, 32'd0);
    check("rst_rty", {31'b0, wb_rty_o}, 32'd0);
    step(); step();
    wb_rst = 1'b1;
    step();

    classic(BASE + 32'h0, 1'b1, 32'hdeadbeef, 4'hF, "cw0");
    classic(BASE + 32'h4, 1'b1, 32'hf00dd00f, 4'hF, "cw1");
    classic(BASE + 32'h8, 1'b1, 32'h01234567, 4'hF, "cw2");
    classic(BASE + 32'hC, 1'b1, 32'h89abcdef, 4'hF, "cw3");
    for (int i = 0; i < 4; i++) classic(BASE + 32'(i * 4), 1'b0, 32'h0, 4'hF, $sformatf("cr%0d", i));
    check("cr_const", ref_mem[1], 32'hf00dd00f);

    classic(BASE + 32'h10, 1'b1, 32'hdeadbeef, 4'hF, "lane_w0");
    classic(BASE + 32'h10, 1'b1, 32'h00001234, 4'h3, "lane_w1");
    classic(BASE + 32'h10, 1'b0, 32'h0, 4'hF, "lane_r");
    check("lane_const", ref_mem[4], 32'hdead1234);

    for (int i = 5; i < DEPTH; i++) classic(BASE + 32'(i * 4), 1'b1, $urandom, 4'hF, "fill");

    for (int k = 0; k < 4; k++) bdat[k] = 32'(k + 1);
    burst(BASE + 32'h8, 2'b00, 1'b1, 4, "lin_w");
    burst(BASE + 32'h8, 2'b00, 1'b0, 4, "lin_r");
    check("lin_const", ref_mem[5], 32'd4);
    burst(BASE + 32'h8, 2'b01, 1'b0, 4, "wrap4_r");

    classic(BASE + 32'h40, 1'b0, 32'h0, 4'hF, "err_oob");
    classic(BASE + 32'h2, 1'b1, 32'h55555555, 4'hF, "err_mis");
    classic(BASE + 32'h0, 1'b0, 32'h0, 4'hF, "err_mis_rd");

    // Burst read aborted by dropping stb after two beats.
    wb_adr_i = BASE; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cti_i = 3'b010; wb_bte_i = 2'b00;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    step();
    check("abort_b0", wb_dat_o, ref_mem[0]);
    step();
    check("abort_b1", wb_dat_o, ref_mem[1]);
    step();
    wb_stb_i = 1'b0;
    check("abort_ack_hold", {31'b0, wb_ack_o}, 32'd1);
    step();
    check("abort_ack_drop", {31'b0, wb_ack_o}, 32'd0);
    step();
    check("abort_idle", {31'b0, wb_ack_o}, 32'd0);
    idle_bus();
    classic(BASE + 32'h14, 1'b0, 32'h0, 4'hF, "abort_next");

    // Reset lands in the first ack cycle of a write burst; that beat must not commit.
    bdat[0] = 32'hAAAA0000; bdat[1] = 32'hAAAA0001;
    wb_adr_i = BASE + 32'h30; wb_we_i = 1'b1; wb_dat_i = bdat[0]; wb_sel_i = 4'hF;
    wb_cti_i = 3'b010; wb_bte_i = 2'b00; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    step();
    check("mrst_ack_pre", {31'b0, wb_ack_o}, 32'd1);
    wb_rst = 1'b0;
    #1;
    check("mrst_ack", {31'b0, wb_ack_o}, 32'd0);
    check("mrst_err", {31'b0, wb_err_o}, 32'd0);
    check("mrst_dat", wb_dat_o, 32'd0);
    step();
    check("mrst_ack_hold", {31'b0, wb_ack_o}, 32'd0);
    idle_bus();
    step();
    wb_rst = 1'b1;
    step();
    classic(BASE + 32'h30, 1'b0, 32'h0, 4'hF, "mrst_rd");

    for (int t = 0; t < 60; t++) begin
      kind = int'($urandom_range(0, 9));
      a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      if (kind < 3) begin
        classic(a, 1'b1, $urandom, 4'($urandom), "rnd_cw");
      end else if (kind < 6) begin
        classic(a, 1'b0, 32'h0, 4'hF, "rnd_cr");
      end else if (kind == 6) begin
        if ($urandom_range(0, 1) == 0) a = a + 32'($urandom_range(1, 3));
        else a = a + 32'(DEPTH * 4 * int'($urandom_range(1, 100)));
        classic(a, $urandom_range(0, 1) == 1, $urandom, 4'hF, "rnd_err");
      end else begin
        len = int'($urandom_range(2, 10));
        for (int k = 0; k < len; k++) bdat[k] = $urandom;
        burst(a, 2'($urandom), $urandom_range(0, 1) == 1, len, "rnd_b");
      end
    end

    for (int i = 0; i < DEPTH; i++) classic(BASE + 32'(i * 4), 1'b0, 32'h0, 4'hF, "final_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
